payload_counted_matcher: RTL
============================

Name: payload_counted_matcher

Overview:
- Parametrised successor to the fixed-pattern payload engines.
- Matches one anchored rule of the form `^PREFIX<class>{MIN,MAX}SUFFIX` against a raw byte stream.
- The class is digit `0`-`9`. Literals are optionally case-insensitive.
- Sits beside the per-rule engines in the payload engine and reports a sticky match plus the byte offset where the match completed.

Parameters:
- PLEN, 5: prefix length in bytes; must be at least 1.
- PREFIX, "PORT=": prefix literal, 8*PLEN bits; byte 0 is the most significant byte.
- SLEN, 8: suffix length in bytes; must be at least 1.
- SUFFIX, "*Victim=": suffix literal, 8*SLEN bits; byte 0 is the most significant byte. SUFFIX byte 0 must not be a digit.
- MIN_REP, 1: minimum digit count; 0 allowed.
- MAX_REP, 0: maximum digit count; 0 means unbounded. Otherwise MAX_REP must be at least MIN_REP and at most 255.
- CASE_INS, 0: when 1, letters A-Z and a-z in PREFIX and SUFFIX compare case-insensitively.
- OFFS_W, 16: width of the offset counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- sod  in  1  start of data; synchronous restart.
- en  in  1  byte valid; all state advances only on en.
- in_byte  in  8  payload byte.
- match  out  1  level; high while the rule has matched in the current payload.
- match_pulse  out  1  single-cycle strobe on the cycle match rises.
- match_offs  out  OFFS_W  offset of the final suffix byte; valid while match is high.
- fail  out  1  level; high once the current payload can no longer match.

Behaviour:
- Reset: rst_n low asynchronously clears everything.
  - FSM goes to PRE, idx=0, cnt=0, pos=0.
  - match, match_pulse, match_offs and fail are all 0.
- Offset counter pos:
  - Counts en bytes since the last sod. The first byte of a payload is position 0.
  - Saturates at all-ones and never wraps.
- sod handling:
  - sod and en together: that byte is position 0 and is evaluated from the PRE state with idx=0.
  - sod without en: state is cleared, and the next en byte is position 0.
  - sod always clears match, fail and match_offs. They are low on the next cycle unless that byte itself completes a match, which is impossible since PLEN+SLEN is at least 2.
- FSM (evaluated only when en is high; outputs registered; match rises the cycle after the completing byte):
  - PRE:
    - Byte equals PREFIX[idx] → idx+1.
    - At idx=PLEN-1 → go to REP with cnt=0.
    - Mismatch → FAIL.
  - REP, byte is a digit:
    - cnt<MAX_REP, or MAX_REP=0 → cnt+1. In unbounded mode cnt saturates at 255; it never wraps.
    - cnt==MAX_REP (bounded) → FAIL.
  - REP, byte is not a digit:
    - cnt>=MIN_REP and byte equals SUFFIX[0] → go to SUF with idx=1, or to HIT if SLEN=1.
    - Anything else → FAIL.
  - SUF:
    - Byte equals SUFFIX[idx] → idx+1.
    - At idx=SLEN-1 → HIT.
    - Mismatch → FAIL.
  - HIT: holds until sod or reset.
    - match=1; match_offs is latched to the pos of the completing byte.
    - match_pulse is high only on the first cycle of HIT.
  - FAIL: holds until sod or reset; fail=1.
- Anchored only: there is no retry at later offsets; a mismatch is final for the payload.
- en low: no state change, pos holds, and outputs hold. match_pulse still drops after one cycle.
- Comparison: CASE_INS=1 folds bit 5 for letters only. Digits and punctuation always compare exactly.

Test Plan:
1. Defaults, sod+en on 'P', then "PORT=1234*Victim=" on consecutive cycles → match rises the cycle after '='; match_offs=16; match_pulse is high exactly 1 cycle; fail=0.
2. Defaults, "PORT=*Victim=" → fail rises the cycle after '*' (position 5); match stays 0.
3. Defaults, "xPORT=1*Victim=" → fail after byte 0; match 0.
4. Case 1 with en low for 2-3 random cycles between bytes → identical result, match_offs=16.
5. MAX_REP=3, CASE_INS=1:
   - "PORT=1234*Victim=" → fail after the 4th digit (position 8).
   - "port=7*victim=" → match, match_offs=13.
6. Reset and restart:
   - rst_n low during REP → all outputs 0 asynchronously.
   - After release, sod+"PORT=9*Victim=" → match_offs=13.
   - A following sod clears match on the next cycle.

Source files
------------

// File: rtl/payload_counted_matcher.sv
// Anchored payload matcher for ^PREFIX[0-9]{MIN,MAX}SUFFIX on a raw byte stream.
// Reports a sticky match and the offset of the completing suffix byte.
//
// state  | meaning
// S_PRE  | comparing prefix bytes, idx = next prefix byte
// S_REP  | counting digits, cnt = digits seen so far
// S_SUF  | comparing suffix bytes, idx = next suffix byte
// S_HIT  | rule matched, held until sod or reset
// S_FAIL | payload can no longer match, held until sod or reset
module payload_counted_matcher #(
  parameter int              PLEN     = 5,
  parameter logic [8*PLEN-1:0] PREFIX = "PORT=",
  parameter int              SLEN     = 8,
  parameter logic [8*SLEN-1:0] SUFFIX = "*Victim=",
  parameter int              MIN_REP  = 1,
  parameter int              MAX_REP  = 0,
  parameter bit              CASE_INS = 1'b0,
  parameter int              OFFS_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sod,
  input  logic              en,
  input  logic [7:0]        in_byte,
  output logic              match,
  output logic              match_pulse,
  output logic [OFFS_W-1:0] match_offs,
  output logic              fail
);

  localparam int LMAX  = (PLEN > SLEN) ? PLEN : SLEN;
  localparam int IDX_W = $clog2(LMAX + 1);
  localparam logic [IDX_W-1:0] PRE_LAST = IDX_W'(PLEN - 1);
  localparam logic [IDX_W-1:0] SUF_LAST = IDX_W'(SLEN - 1);
  localparam bit UNBOUNDED = (MAX_REP == 0);

  typedef enum logic [2:0] {S_PRE, S_REP, S_SUF, S_HIT, S_FAIL} state_t;

  state_t            state_q, state_d, st;
  logic [IDX_W-1:0]  idx_q, idx_d, ix;
  logic [7:0]        cnt_q, cnt_d, cn;
  logic [OFFS_W-1:0] pos_q, pos_d, cur_pos;
  logic [OFFS_W-1:0] offs_d;
  logic              match_d, fail_d, pulse_d;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= 8'h30) && (b <= 8'h39);
  endfunction

  function automatic logic is_alpha(input logic [7:0] b);
    return ((b >= 8'h41) && (b <= 8'h5A)) || ((b >= 8'h61) && (b <= 8'h7A));
  endfunction

  // Case folding applies to letters only; digits and punctuation stay exact.
  function automatic logic lit_eq(input logic [7:0] b, input logic [7:0] lit);
    if (CASE_INS && is_alpha(lit) && is_alpha(b))
      return (b | 8'h20) == (lit | 8'h20);
    return b == lit;
  endfunction

  function automatic logic [7:0] pre_byte(input logic [IDX_W-1:0] i);
    logic [7:0] r;
    r = 8'h00;
    for (int k = 0; k < PLEN; k++)
      if (i == IDX_W'(k)) r = PREFIX[8*(PLEN-1-k) +: 8];
    return r;
  endfunction

  function automatic logic [7:0] suf_byte(input logic [IDX_W-1:0] i);
    logic [7:0] r;
    r = 8'h00;
    for (int k = 0; k < SLEN; k++)
      if (i == IDX_W'(k)) r = SUFFIX[8*(SLEN-1-k) +: 8];
    return r;
  endfunction

  // sod together with en evaluates the byte as if from a freshly cleared context.
  always_comb begin
    st      = sod ? S_PRE : state_q;
    ix      = sod ? '0 : idx_q;
    cn      = sod ? '0 : cnt_q;
    cur_pos = sod ? '0 : pos_q;
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    pos_d   = pos_q;
    match_d = match;
    fail_d  = fail;
    offs_d  = match_offs;
    pulse_d = 1'b0;
    if (en) begin
      state_d = st;
      idx_d   = ix;
      cnt_d   = cn;
      pos_d   = (&cur_pos) ? cur_pos : cur_pos + OFFS_W'(1);
      unique case (st)
        S_PRE: begin
          if (lit_eq(in_byte, pre_byte(ix))) begin
            if (ix == PRE_LAST) begin
              state_d = S_REP;
              idx_d   = '0;
              cnt_d   = '0;
            end else begin
              idx_d = ix + IDX_W'(1);
            end
          end else begin
            state_d = S_FAIL;
          end
        end
        S_REP: begin
          if (is_digit(in_byte)) begin
            if (UNBOUNDED)
              cnt_d = (&cn) ? cn : cn + 8'd1;
            else if (int'(cn) < MAX_REP)
              cnt_d = cn + 8'd1;
            else
              state_d = S_FAIL;
          end else if ((int'(cn) >= MIN_REP) && lit_eq(in_byte, suf_byte(IDX_W'(0)))) begin
            if (SLEN == 1) begin
              state_d = S_HIT;
            end else begin
              state_d = S_SUF;
              idx_d   = IDX_W'(1);
            end
          end else begin
            state_d = S_FAIL;
          end
        end
        S_SUF: begin
          if (lit_eq(in_byte, suf_byte(ix))) begin
            if (ix == SUF_LAST) state_d = S_HIT;
            else                idx_d   = ix + IDX_W'(1);
          end else begin
            state_d = S_FAIL;
          end
        end
        default: ;
      endcase
      match_d = (state_d == S_HIT);
      fail_d  = (state_d == S_FAIL);
      offs_d  = sod ? '0 : match_offs;
      if ((state_d == S_HIT) && (st != S_HIT)) begin
        offs_d  = cur_pos;
        pulse_d = 1'b1;
      end
    end else if (sod) begin
      state_d = S_PRE;
      idx_d   = '0;
      cnt_d   = '0;
      pos_d   = '0;
      match_d = 1'b0;
      fail_d  = 1'b0;
      offs_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_PRE;
      idx_q       <= '0;
      cnt_q       <= '0;
      pos_q       <= '0;
      match       <= 1'b0;
      match_pulse <= 1'b0;
      match_offs  <= '0;
      fail        <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      pos_q       <= pos_d;
      match       <= match_d;
      match_pulse <= pulse_d;
      match_offs  <= offs_d;
      fail        <= fail_d;
    end
  end

endmodule
